mem_wb_stage: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM buffer.
- Consumes the buffer's ALU result (address), RD2 (store data), Zf, branch-target adder and destination register.
- Performs the data-memory access over a variable-latency req/ack interface, stalling upstream while it waits.
- Resolves branches (pcSrc) and registers the MEM/WB results for write-back.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/mem_wb_stage_if.sv | 17 +
 rtl/buffer_d.sv | 24 ++
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the MEM stage: FSM state encoding, datapath widths and
// the MEM/WB register payload.
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              valid;
  } wb_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Variable-latency data-memory request/acknowledge bus between the MEM stage
// (master) and the memory (slave).
interface mem_wb_stage_if;
  import pipeline_pkg::*;

  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memAck;

  modport master (output memReq, memWe, memAddr, memWData,
                  input  memRData, memAck);
  modport slave  (input  memReq, memWe, memAddr, memWData,
                  output memRData, memAck);
endinterface

// File: rtl/buffer_d.sv
// MEM/WB pipeline register: bubble clears the slot, load captures d,
// otherwise the contents hold.
module buffer_d
  import pipeline_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory access over a req/ack bus with timeout, branch
// resolution, and the MEM/WB register feeding write-back.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inAdder,
  input  logic              inZf,
  input  logic [DATA_W-1:0] inOutAlu,
  input  logic [DATA_W-1:0] inRD2,
  input  logic [REG_W-1:0]  inMux5b,
  input  logic              inValid,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inRegWrite,
  input  logic              inMemToReg,
  input  logic              inBranch,
  mem_wb_stage_if.master    mem,
  output logic              stall,
  output logic              pcSrc,
  output logic [DATA_W-1:0] branchTarget,
  output logic [DATA_W-1:0] outReadData,
  output logic [DATA_W-1:0] outAluResult,
  output logic [REG_W-1:0]  outWriteReg,
  output logic              outRegWrite,
  output logic              outMemToReg,
  output logic              outValid,
  output logic              outBusErr,
  output logic              outMisaligned
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [REG_W-1:0] lat_reg;
  logic             lat_rw;
  logic             lat_m2r;
  logic             lat_read;

  logic mem_op, aligned, issue, misalign, ack_hit;
  wb_t  wb_d, wb_q;
  logic wb_load;

  assign mem_op   = inMemRead | inMemWrite;
  assign aligned  = (inOutAlu[1:0] == 2'b00);
  assign issue    = (state == IDLE) & inValid & mem_op & aligned;
  assign misalign = (state == IDLE) & inValid & mem_op & ~aligned;
  assign ack_hit  = (state == WAIT) & mem.memAck;

  // Gated by rst_n so the upstream sees no stall or redirect while in reset.
  assign stall        = rst_n & (issue | (state == WAIT));
  assign pcSrc        = rst_n & (state == IDLE) & inValid & inBranch & inZf;
  assign branchTarget = inAdder;

  always_comb begin
    wb_d    = '0;
    wb_load = 1'b0;
    if ((state == IDLE) && !issue && !misalign) begin
      wb_load         = 1'b1;
      wb_d.alu_result = inOutAlu;
      wb_d.write_reg  = inMux5b;
      wb_d.reg_write  = inRegWrite & inValid;
      wb_d.mem_to_reg = inMemToReg;
      wb_d.valid      = inValid;
    end else if (ack_hit) begin
      wb_load         = 1'b1;
      wb_d.read_data  = lat_read ? mem.memRData : '0;
      wb_d.alu_result = mem.memAddr;
      wb_d.write_reg  = lat_reg;
      wb_d.reg_write  = lat_rw;
      wb_d.mem_to_reg = lat_m2r;
      wb_d.valid      = 1'b1;
    end
  end

  // Access FSM; acknowledge takes priority over the timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.memReq    <= 1'b0;
      mem.memWe     <= 1'b0;
      mem.memAddr   <= '0;
      mem.memWData  <= '0;
      lat_reg       <= '0;
      lat_rw        <= 1'b0;
      lat_m2r       <= 1'b0;
      lat_read      <= 1'b0;
      outBusErr     <= 1'b0;
      outMisaligned <= 1'b0;
    end else begin
      outBusErr     <= 1'b0;
      outMisaligned <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (issue) begin
            state        <= WAIT;
            mem.memReq   <= 1'b1;
            mem.memWe    <= inMemWrite;
            mem.memAddr  <= {inOutAlu[DATA_W-1:2], 2'b00};
            mem.memWData <= inRD2;
            lat_reg      <= inMux5b;
            lat_rw       <= inRegWrite;
            lat_m2r      <= inMemToReg;
            lat_read     <= inMemRead & ~inMemWrite;
          end else if (misalign) begin
            outMisaligned <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem.memAck) begin
            mem.memReq <= 1'b0;
            state      <= DONE;
          end else if (cnt == TO_LAST) begin
            mem.memReq <= 1'b0;
            outBusErr  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  buffer_d u_buffer_d (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wb_load),
    .bubble (~wb_load),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign outReadData  = wb_q.read_data;
  assign outAluResult = wb_q.alu_result;
  assign outWriteReg  = wb_q.write_reg;
  assign outRegWrite  = wb_q.reg_write;
  assign outMemToReg  = wb_q.mem_to_reg;
  assign outValid     = wb_q.valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then random instructions,
// each checked against a per-instruction behavioural model.
module tb_mem_wb_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inAdder, inOutAlu, inRD2;
  logic        inZf, inValid, inMemRead, inMemWrite, inRegWrite, inMemToReg, inBranch;
  logic [4:0]  inMux5b;
  logic        stall, pcSrc, outRegWrite, outMemToReg, outValid, outBusErr, outMisaligned;
  logic [31:0] branchTarget, outReadData, outAluResult;
  logic [4:0]  outWriteReg;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] env_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  mem_wb_stage_if mem ();

  mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .inAdder(inAdder), .inZf(inZf), .inOutAlu(inOutAlu),
    .inRD2(inRD2), .inMux5b(inMux5b), .inValid(inValid), .inMemRead(inMemRead),
    .inMemWrite(inMemWrite), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
    .inBranch(inBranch), .mem(mem), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .outReadData(outReadData), .outAluResult(outAluResult),
    .outWriteReg(outWriteReg), .outRegWrite(outRegWrite), .outMemToReg(outMemToReg),
    .outValid(outValid), .outBusErr(outBusErr), .outMisaligned(outMisaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  // ack_lat: WAIT cycle (1-based) in which memAck is raised; 0 means never.
  task automatic run_instr(input logic v, input logic rd, input logic wr, input logic rw,
                           input logic m2r, input logic br, input logic zf,
                           input logic [31:0] alu, input logic [31:0] rd2,
                           input logic [31:0] adder, input logic [4:0] rg, input int ack_lat);
    logic access, misal, acked, exp_beat, done, s;
    int exp_wait, exp_stall;
    logic [31:0] exp_rdata;
    int stall_n, req_n, beats, err_n, mis_n, pc_n, rw_bub;
    logic [31:0] c_rdata, c_alu;
    logic [4:0]  c_reg;
    logic        c_rw, c_m2r;

    access    = v & (rd | wr) & (alu[1:0] == 2'b00);
    misal     = v & (rd | wr) & (alu[1:0] != 2'b00);
    acked     = access && ack_lat >= 1 && ack_lat <= TMO;
    exp_wait  = access ? (acked ? ack_lat : TMO) : 0;
    exp_stall = access ? 1 + exp_wait : 0;
    exp_beat  = (v && !access && !misal) || acked;
    exp_rdata = (acked && rd && !wr) ? model_rd(alu) : 32'h0;
    if (acked && wr) model_mem[alu] = rd2;

    @(negedge clk);
    inValid = v; inMemRead = rd; inMemWrite = wr; inRegWrite = rw; inMemToReg = m2r;
    inBranch = br; inZf = zf; inOutAlu = alu; inRD2 = rd2; inAdder = adder; inMux5b = rg;
    stall_n = 0; req_n = 0; beats = 0; err_n = 0; mis_n = 0; pc_n = 0; rw_bub = 0;
    c_rdata = 'x; c_alu = 'x; c_reg = 'x; c_rw = 'x; c_m2r = 'x; done = 1'b0;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall) stall_n++;
      if (pcSrc) pc_n++;
      if (cyc == 0) check("branchTarget", branchTarget, adder);
      if (mem.memReq) begin
        req_n++;
        check("memAddr", mem.memAddr, alu);
        check("memWe", 32'(mem.memWe), 32'(wr));
        check("memWData", mem.memWData, rd2);
        mem.memAck   = (req_n == ack_lat);
        mem.memRData = mem.memAck ? env_rd(mem.memAddr) : $urandom();
        if (mem.memAck && mem.memWe) env_mem[mem.memAddr] = mem.memWData;
      end else begin
        mem.memAck   = 1'($urandom_range(0, 1));
        mem.memRData = $urandom();
      end
      s = stall;
      @(posedge clk);
      #1;
      mem.memAck = 1'b0;
      if (outValid) begin
        beats++;
        c_rdata = outReadData; c_alu = outAluResult; c_reg = outWriteReg;
        c_rw = outRegWrite; c_m2r = outMemToReg;
      end else if (outRegWrite) begin
        rw_bub++;
      end
      if (outBusErr) err_n++;
      if (outMisaligned) mis_n++;
      if (!s) done = 1'b1;
      else @(negedge clk);
    end

    check("finished_in_budget", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    check("req_cycles", 32'(req_n), 32'(exp_wait));
    check("valid_beats", 32'(beats), exp_beat ? 32'd1 : 32'd0);
    check("regwrite_in_bubble", 32'(rw_bub), 32'd0);
    check("buserr_pulses", 32'(err_n), (access && !acked) ? 32'd1 : 32'd0);
    check("misaligned_pulses", 32'(mis_n), misal ? 32'd1 : 32'd0);
    check("pcsrc_cycles", 32'(pc_n), (v & br & zf) ? 32'd1 : 32'd0);
    if (exp_beat) begin
      check("outReadData", c_rdata, exp_rdata);
      check("outAluResult", c_alu, alu);
      check("outWriteReg", 32'(c_reg), 32'(rg));
      check("outRegWrite", 32'(c_rw), 32'(rw));
      check("outMemToReg", 32'(c_m2r), 32'(m2r));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inAdder = '0; inOutAlu = '0; inRD2 = '0; inMux5b = '0; inZf = 0; inValid = 0;
    inMemRead = 0; inMemWrite = 0; inRegWrite = 0; inMemToReg = 0; inBranch = 0;
    mem.memAck = 1'b0; mem.memRData = '0;
    env_mem[32'h40] = 32'hDEAD_BEEF;
    model_mem[32'h40] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    check("reset_memReq", 32'(mem.memReq), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_outValid", 32'(outValid), 32'd0);
    check("reset_outAluResult", outAluResult, 32'd0);
    check("reset_outBusErr", 32'(outBusErr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(1, 0, 0, 1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd5, 0);             // ALU op
    run_instr(1, 1, 0, 1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 5'd7, 2);             // load, ack in 2nd WAIT
    run_instr(1, 0, 1, 0, 0, 0, 0, 32'h44, 32'h1234_5678, 32'h0, 5'd0, 1);     // store
    run_instr(1, 1, 0, 1, 1, 0, 0, 32'h42, 32'h0, 32'h0, 5'd3, 1);             // misaligned
    run_instr(1, 1, 0, 1, 1, 0, 0, 32'h48, 32'h0, 32'h0, 5'd4, 0);             // timeout
    run_instr(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h100, 5'd0, 0);            // branch taken
    run_instr(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h100, 5'd0, 0);            // branch not taken
    run_instr(0, 1, 0, 1, 1, 1, 1, 32'h40, 32'h0, 32'h200, 5'd9, 1);           // invalid slot
    run_instr(1, 1, 0, 1, 1, 0, 0, 32'h44, 32'h0, 32'h0, 5'd6, 1);             // load-after-store, fast ack

    // Reset asserted while an access is outstanding.
    @(negedge clk);
    inValid = 1; inMemRead = 1; inMemWrite = 0; inRegWrite = 1; inBranch = 1; inZf = 1;
    inOutAlu = 32'h50;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midwait_memReq_before", 32'(mem.memReq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwait_memReq", 32'(mem.memReq), 32'd0);
    check("midwait_stall", 32'(stall), 32'd0);
    check("midwait_pcSrc", 32'(pcSrc), 32'd0);
    check("midwait_outValid", 32'(outValid), 32'd0);
    check("midwait_outRegWrite", 32'(outRegWrite), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_stall_idle", 32'(stall), 32'd1);
    check("release_memReq", 32'(mem.memReq), 32'd0);
    inValid = 0; inBranch = 0;
    #1;
    check("release_no_stall", 32'(stall), 32'd0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      if (kind == 0) a = $urandom();
      else a = {26'b0, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      run_instr(1'($urandom_range(0, 7) != 0), kind == 1, kind == 2,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                a, $urandom(), $urandom(), 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
